// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file widths, types and writeback requester indices
package rf_pkg;
  localparam int RF_AW = 5;
  localparam int RF_DW = 32;

  typedef logic [RF_AW-1:0] rf_addr_t;
  typedef logic [RF_DW-1:0] rf_data_t;

  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter with one-hot grant
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic r_prio;
  logic [1:0] w_gnt;

  // A lone requester always wins; on contention the prio side wins.
  always_comb begin
    w_gnt = 2'b00;
    if (!reset) begin
      w_gnt[0] = req[0] & (~req[1] | ~r_prio);
      w_gnt[1] = req[1] & (~req[0] |  r_prio);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio <= 1'b0;
    end else if (|w_gnt) begin
      r_prio <= w_gnt[0];
    end
  end

  assign gnt = w_gnt;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the register-file write port between ALU and load unit
// and tracks pending writes for read-after-write hazard queries.
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int N = RF_AW,
  parameter int W = RF_DW
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [N-1:0] req_addr0,
  input  logic [N-1:0] req_addr1,
  input  logic [W-1:0] req_data0,
  input  logic [W-1:0] req_data1,
  input  logic         rsv_valid,
  input  logic [N-1:0] rsv_addr,
  input  logic [N-1:0] q_addr1,
  input  logic [N-1:0] q_addr2,
  output logic         busy1,
  output logic         busy2,
  output logic         we3,
  output logic [N-1:0] wa3,
  output logic [W-1:0] wd3
);
  localparam int NREG = 2**N;

  logic [1:0]      w_gnt;
  logic [N-1:0]    w_sel_addr;
  logic [W-1:0]    w_sel_data;
  logic            r_we3;
  logic [N-1:0]    r_wa3;
  logic [W-1:0]    r_wd3;
  logic [NREG-1:0] r_sb;
  logic [NREG-1:0] w_sb_nxt;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req_valid),
    .gnt   (w_gnt)
  );

  assign req_ready  = w_gnt;
  assign w_sel_addr = w_gnt[REQ_LSU] ? req_addr1 : req_addr0;
  assign w_sel_data = w_gnt[REQ_LSU] ? req_data1 : req_data0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_we3 <= 1'b0;
      r_wa3 <= '0;
      r_wd3 <= '0;
    end else if (w_gnt[REQ_ALU] || w_gnt[REQ_LSU]) begin
      r_we3 <= 1'b1;
      r_wa3 <= w_sel_addr;
      r_wd3 <= w_sel_data;
    end else begin
      r_we3 <= 1'b0;
    end
  end

  // Clear applied before set so a fresh reservation survives a same-edge commit.
  always_comb begin
    w_sb_nxt = r_sb;
    if (r_we3) begin
      w_sb_nxt[r_wa3] = 1'b0;
    end
    if (rsv_valid && (rsv_addr != '0)) begin
      w_sb_nxt[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sb <= '0;
    end else begin
      r_sb <= w_sb_nxt;
    end
  end

  assign busy1 = r_sb[q_addr1];
  assign busy2 = r_sb[q_addr2];
  assign we3   = r_we3;
  assign wa3   = r_wa3;
  assign wd3   = r_wd3;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  import rf_pkg::*;

  logic       clk;
  logic       reset;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  rf_addr_t   req_addr0, req_addr1;
  rf_data_t   req_data0, req_data1;
  logic       rsv_valid;
  rf_addr_t   rsv_addr;
  rf_addr_t   q_addr1, q_addr2;
  logic       busy1, busy2;
  logic       we3;
  rf_addr_t   wa3;
  rf_data_t   wd3;

  int n_pass  = 0;
  int n_total = 0;

  regfile_wb_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr0 (req_addr0),
    .req_addr1 (req_addr1),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .q_addr1   (q_addr1),
    .q_addr2   (q_addr2),
    .busy1     (busy1),
    .busy2     (busy2),
    .we3       (we3),
    .wa3       (wa3),
    .wd3       (wd3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1; req_valid = 2'b11;
    req_addr0 = 5'd3; req_data0 = 32'hA; req_addr1 = 5'd4; req_data1 = 32'hB;
    rsv_valid = 1'b1; rsv_addr = 5'd5; q_addr1 = 5'd5; q_addr2 = 5'd0;
    #1;
    chk("rst_ready_comb", req_ready, 2'b00);
    tick();
    tick();
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_we3", we3, 1'b0);
    chk("rst_wa3", wa3, 5'd0);
    chk("rst_wd3", wd3, 32'd0);
    chk("rst_busy1", busy1, 1'b0);
    chk("rst_busy2", busy2, 1'b0);

    // Contention: grants alternate starting with requester 0
    reset = 1'b0; rsv_valid = 1'b0; #1;
    chk("cont_gnt0", req_ready, 2'b01);
    tick();
    chk("cont_we3_a", we3, 1'b1); chk("cont_wa3_a", wa3, 5'd3); chk("cont_wd3_a", wd3, 32'hA);
    chk("cont_gnt1", req_ready, 2'b10);
    tick();
    chk("cont_we3_b", we3, 1'b1); chk("cont_wa3_b", wa3, 5'd4); chk("cont_wd3_b", wd3, 32'hB);
    chk("cont_gnt2", req_ready, 2'b01);
    tick();
    chk("cont_we3_c", we3, 1'b1); chk("cont_wa3_c", wa3, 5'd3);
    chk("cont_gnt3", req_ready, 2'b10);
    tick();
    chk("cont_we3_d", we3, 1'b1); chk("cont_wa3_d", wa3, 5'd4);

    // Single requester 1 with prio back at 0
    req_valid = 2'b10; req_data1 = 32'h11; #1;
    chk("single_gnt_a", req_ready, 2'b10);
    tick();
    chk("single_wd3_a", wd3, 32'h11);
    req_data1 = 32'h22; #1;
    chk("single_gnt_b", req_ready, 2'b10);
    tick();
    chk("single_wd3_b", wd3, 32'h22);
    req_data1 = 32'h33; #1;
    chk("single_gnt_c", req_ready, 2'b10);
    tick();
    chk("single_wd3_c", wd3, 32'h33); chk("single_we3_c", we3, 1'b1);
    req_valid = 2'b00; #1;
    chk("idle_ready", req_ready, 2'b00);
    tick();
    chk("idle_we3", we3, 1'b0); chk("idle_wa3_hold", wa3, 5'd4); chk("idle_wd3_hold", wd3, 32'h33);

    // Scoreboard lifecycle on x7
    rsv_valid = 1'b1; rsv_addr = 5'd7; q_addr1 = 5'd7; #1;
    chk("sb_nobypass", busy1, 1'b0);
    tick();
    rsv_valid = 1'b0;
    chk("sb_t1", busy1, 1'b1);
    tick();
    chk("sb_t2", busy1, 1'b1);
    req_valid = 2'b01; req_addr0 = 5'd7; req_data0 = 32'h77; #1;
    chk("sb_gnt_t3", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    chk("sb_we3_t4", we3, 1'b1); chk("sb_wa3_t4", wa3, 5'd7);
    chk("sb_busy_t4", busy1, 1'b1);
    tick();
    chk("sb_busy_t5", busy1, 1'b0); chk("sb_we3_t5", we3, 1'b0);

    // Set/clear collision on x9 (prio is now 1)
    rsv_valid = 1'b1; rsv_addr = 5'd9; q_addr2 = 5'd9;
    req_valid = 2'b10; req_addr1 = 5'd9; req_data1 = 32'h99; #1;
    chk("col_gnt", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    chk("col_we3", we3, 1'b1); chk("col_wa3", wa3, 5'd9); chk("col_busy_pre", busy2, 1'b1);
    tick();
    rsv_valid = 1'b0;
    chk("col_set_wins", busy2, 1'b1);
    req_valid = 2'b01; req_addr0 = 5'd9; req_data0 = 32'h9A; #1;
    chk("col_gnt2", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    chk("col_wa3_2", wa3, 5'd9);
    tick();
    chk("col_cleared", busy2, 1'b0);

    // x0 handling (prio is now 1)
    rsv_valid = 1'b1; rsv_addr = 5'd0; q_addr1 = 5'd0;
    tick();
    rsv_valid = 1'b0;
    chk("x0_not_busy", busy1, 1'b0);
    req_valid = 2'b10; req_addr1 = 5'd0; req_data1 = 32'h5; #1;
    chk("x0_gnt", req_ready, 2'b10);
    tick();
    chk("x0_we3", we3, 1'b1); chk("x0_wa3", wa3, 5'd0); chk("x0_wd3", wd3, 32'h5);
    req_valid = 2'b11; req_addr0 = 5'd1; req_addr1 = 5'd2; #1;
    chk("x0_prio_flip", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    chk("x0_busy_after", busy1, 1'b0);

    // Mid-run reset discards reservations and pending writes
    rsv_valid = 1'b1; rsv_addr = 5'd13; q_addr2 = 5'd13; req_valid = 2'b10;
    tick();
    rsv_valid = 1'b0;
    chk("mrst_busy_pre", busy2, 1'b1);
    reset = 1'b1; req_valid = 2'b11; #1;
    chk("mrst_ready", req_ready, 2'b00);
    tick();
    chk("mrst_busy", busy2, 1'b0); chk("mrst_we3", we3, 1'b0); chk("mrst_wa3", wa3, 5'd0);
    reset = 1'b0; #1;
    chk("mrst_prio0", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    chk("mrst_wa3_after", wa3, 5'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port between two writeback requesters: requester 0 is the ALU and requester 1 is the load unit. It also keeps a pending-write scoreboard that the issue stage queries for read-after-write hazards. The block sits between the writeback sources and the register file's `we3`/`wa3`/`wd3` port, and it registers the selected write for one cycle.

## Interface
Parameters:
- `N`, 5, register address width; the file has 2**N registers.
- `W`, 32, data width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  2  per-requester write request.
- `req_ready`  out  2  per-requester grant; a request is accepted when `req_valid[i] && req_ready[i]`.
- `req_addr0`, `req_addr1`  in  N  destination register.
- `req_data0`, `req_data1`  in  W  write data.
- `rsv_valid`  in  1  issue stage reserves a destination register.
- `rsv_addr`  in  N  register to reserve.
- `q_addr1`, `q_addr2`  in  N  hazard query addresses.
- `busy1`, `busy2`  out  1  the queried register has a pending write.
- `we3`  out  1  register file write enable, registered.
- `wa3`  out  N  register file write address, registered.
- `wd3`  out  W  register file write data, registered.

## Operation
- **Arbitration:**
  - At most one request is granted per cycle.
  - `req_ready` is combinational from `req_valid` and the priority pointer `prio` (1 bit).
  - `req_ready` is never asserted to a requester whose `req_valid` is low.
- **Round-robin:**
  - When only one requester is valid, it is granted.
  - When both are valid, requester `prio` is granted.
  - After any grant, `prio` becomes the index of the requester not granted.
  - With no grant, `prio` holds its value.
- **Write stage:**
  - On an accepted request, the next edge loads `we3`=1, `wa3`=the request address and `wd3`=the request data.
  - With no grant, `we3` is cleared to 0. `wa3` and `wd3` hold their values.
  - The register file always absorbs the write, so the arbiter never stalls.
- **Register x0:**
  - A request to address 0 is granted and consumes the round-robin turn.
  - Its output write is still issued; the register file ignores writes to x0.
  - `rsv_addr`=0 is ignored, so x0 is never marked busy.
- **Scoreboard:**
  - `sb` is a 2**N-bit vector.
  - `rsv_valid` with a nonzero address sets `sb[rsv_addr]` at the next edge.
  - An output write (`we3`=1) clears `sb[wa3]` at the same edge that commits the data.
  - If a set and a clear hit the same address on the same edge, the set wins; the new reservation survives.
- **Query:** `busy1`=`sb[q_addr1]` and `busy2`=`sb[q_addr2]`, combinational, with no bypass of same-cycle set or clear.
- **Reset:**
  - State after reset: `prio`=0, `sb`=0, `we3`=0, `wa3`=0, `wd3`=0.
  - A request presented in the reset cycle is not granted; `req_ready`=0 while `reset` is high.
  - Any reservation or write in flight when reset asserts is discarded.

## Timing
- Request accepted in cycle t → `we3` high during cycle t+1 → data is visible on the register file read ports in cycle t+2.
- Reservation in cycle t → `busy` reads high from cycle t+1.
- Commit edge ending cycle t+1 → `busy` reads low from cycle t+2, the same cycle the new data is readable.
- Throughput is one write per cycle.
- Worst-case wait for a continuously valid requester is 1 cycle.
- Combinational paths:
  - `req_valid` → `req_ready`.
  - `q_addr` → `busy`.
- All other outputs are registered.

## Structure
- Shared package `rf_pkg`:
  - `RF_AW`=5 and `RF_DW`=32 defaults.
  - `rf_addr_t` and `rf_data_t` typedefs.
  - `REQ_ALU`=0 and `REQ_LSU`=1 requester index constants.
- Sub-module `rr_arbiter2` holds the `prio` flop and the grant logic: 2-bit `req` in, 2-bit one-hot `gnt` out.
- The scoreboard and the write-stage registers stay in the top module.

## Test plan
- **Reset:** hold `reset` with `req_valid`=2'b11 → `req_ready`=0, `we3`=0, `busy1`=`busy2`=0. After release, the first dual request grants requester 0.
- **Contention:** both requesters valid for 4 cycles, addr0=3/data0=0xA, addr1=4/data1=0xB → grants alternate 0,1,0,1. `we3` is high on 4 consecutive cycles with `wa3` sequence 3,4,3,4.
- **Single requester:** requester 1 alone for 3 cycles after `prio` was set to 0 → requester 1 is granted every cycle and `wd3` follows its data one cycle later.
- **Scoreboard lifecycle:** reserve 7 at t0 → `busy1`(q=7)=1 from t1. Write to 7 accepted at t3 → `we3` at t4, `busy1`=0 from t5.
- **Set/clear collision:** reservation of 9 in the same cycle that `we3`=1 with `wa3`=9 → `sb[9]` remains 1 and `busy`=1 next cycle.
- **x0 handling:** `rsv_addr`=0 → `busy` for q=0 stays 0. Request to x0 → granted, `we3`=1 with `wa3`=0, and `prio` flips.
